// File: rtl/sseg_scan_sched_if.sv
// Requester write port of the 7-segment scan scheduler: valid/ready handshake
// carrying a digit index and its segment pattern (bit7 = DP).
interface sseg_scan_sched_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_idx;
    logic [7:0] wr_data;

    modport master (output wr_valid, output wr_idx, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_idx, input wr_data, output wr_ready);
endinterface

// File: rtl/sseg_scan_sched.sv
// Time-multiplexed 8-digit 7-segment scan scheduler with per-digit blanking and PWM dimming.
// Optional build macro SCAN_DIGIT_MASK_EN adds a digit_mask input that skips masked digits.
module sseg_scan_sched #(
    parameter int unsigned NDIGITS   = 8,
    parameter int unsigned SLOT_CYC  = 256,
    parameter int unsigned BLANK_CYC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [3:0]         duty,
`ifdef SCAN_DIGIT_MASK_EN
    input  logic [NDIGITS-1:0] digit_mask,
`endif
    sseg_scan_sched_if.slave   wr,
    output logic [7:0]         sseg,
    output logic [2:0]         sel3,
    output logic               pwm,
    output logic               frame_done
);

    localparam int unsigned CNT_MAX = (SLOT_CYC > BLANK_CYC) ? SLOT_CYC : BLANK_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
`ifndef SCAN_DIGIT_MASK_EN
    localparam logic [2:0] LAST_IDX = 3'(NDIGITS - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_BLANK  = 2'd2,
        S_DRIVE  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [2:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             commit;

    logic [7:0] shadow [NDIGITS];
    logic [7:0] active [NDIGITS];
    logic [3:0] duty_act;

    logic [7:0] sseg_n;
    logic [2:0] sel3_n;
    logic       pwm_n;
    logic       frame_done_n;
    logic       wr_ready_q, wr_ready_n;
    logic       wr_fire;

`ifdef SCAN_DIGIT_MASK_EN
    logic [NDIGITS-1:0] mask_act;
    logic [3:0]         nxt;

    // Lowest set bit of m at or above position from; bit 3 flags that one exists.
    function automatic logic [3:0] next_set(input logic [NDIGITS-1:0] m, input int from);
        logic [3:0] r;
        r = 4'd0;
        for (int i = int'(NDIGITS) - 1; i >= 0; i--) begin
            if (i >= from && m[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction
`endif

    // State register plus registered Moore outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= 3'd0;
            cnt        <= '0;
            sseg       <= 8'd0;
            sel3       <= 3'd0;
            pwm        <= 1'b0;
            frame_done <= 1'b0;
            wr_ready_q <= 1'b1;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            sseg       <= sseg_n;
            sel3       <= sel3_n;
            pwm        <= pwm_n;
            frame_done <= frame_done_n;
            wr_ready_q <= wr_ready_n;
        end
    end

    // Next-state: slot sequencing, frame wrap and enable drop-out.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        commit  = 1'b0;
`ifdef SCAN_DIGIT_MASK_EN
        nxt     = 4'd0;
`endif
        if (!enable) begin
            state_n = S_IDLE;
            idx_n   = 3'd0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_n = S_COMMIT;
                    idx_n   = 3'd0;
                    cnt_n   = '0;
                end
                S_COMMIT: begin
                    commit = 1'b1;
                    cnt_n  = '0;
`ifdef SCAN_DIGIT_MASK_EN
                    nxt     = next_set(digit_mask, 0);
                    state_n = nxt[3] ? S_BLANK : S_COMMIT;
                    idx_n   = nxt[2:0];
`else
                    state_n = S_BLANK;
                    idx_n   = 3'd0;
`endif
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n = S_DRIVE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_DRIVE: begin
                    if (cnt == SLOT_LAST) begin
                        cnt_n = '0;
`ifdef SCAN_DIGIT_MASK_EN
                        nxt = next_set(mask_act, int'(idx) + 1);
                        if (nxt[3]) begin
                            state_n = S_BLANK;
                            idx_n   = nxt[2:0];
                        end else begin
                            state_n = S_COMMIT;
                            idx_n   = 3'd0;
                        end
`else
                        if (idx == LAST_IDX) begin
                            state_n = S_COMMIT;
                            idx_n   = 3'd0;
                        end else begin
                            state_n = S_BLANK;
                            idx_n   = idx + 3'd1;
                        end
`endif
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so outputs change on the state-change edge.
    always_comb begin
        sseg_n       = 8'd0;
        sel3_n       = 3'd0;
        pwm_n        = 1'b0;
        frame_done_n = 1'b0;
        wr_ready_n   = 1'b1;
        unique case (state_n)
            S_COMMIT: begin
                frame_done_n = 1'b1;
                wr_ready_n   = 1'b0;
            end
            S_BLANK: sel3_n = idx_n;
            S_DRIVE: begin
                sel3_n = idx_n;
                sseg_n = active[idx_n];
                pwm_n  = (cnt_n[3:0] < duty_act);
            end
            default: ;
        endcase
    end

    assign wr.wr_ready = wr_ready_q;
    assign wr_fire     = wr.wr_valid && wr_ready_q;

    // Shadow bank takes requester writes; it is copied to the active bank only at commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NDIGITS); i++) begin
                shadow[i] <= 8'd0;
                active[i] <= 8'd0;
            end
            duty_act <= 4'd0;
`ifdef SCAN_DIGIT_MASK_EN
            mask_act <= '0;
`endif
        end else begin
            if (wr_fire && (32'(wr.wr_idx) < NDIGITS)) begin
                shadow[wr.wr_idx] <= wr.wr_data;
            end
            if (commit) begin
                for (int i = 0; i < int'(NDIGITS); i++) begin
                    active[i] <= shadow[i];
                end
                duty_act <= duty;
`ifdef SCAN_DIGIT_MASK_EN
                mask_act <= digit_mask;
`endif
            end
        end
    end

endmodule
